// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: opcode constants, bubble encoding,
// fetch FSM states and a small HLT decode helper.
package fetch_stage_pkg;

  typedef logic [15:0] word_t;

  localparam logic [3:0] OP_B   = 4'b1100;
  localparam logic [3:0] OP_BR  = 4'b1101;
  localparam logic [3:0] OP_PCS = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam word_t NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_MISS  = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  function automatic logic is_hlt(input word_t instr);
    return instr[15:12] == OP_HLT;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-cache request/response bus between the fetch stage (master)
// and the instruction cache (slave).
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  word_t imem_addr;
  logic  imem_req;
  word_t imem_instr;
  logic  imem_valid;

  modport master (
    output imem_addr,
    output imem_req,
    input  imem_instr,
    input  imem_valid
  );

  modport slave (
    input  imem_addr,
    input  imem_req,
    output imem_instr,
    output imem_valid
  );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load a fetched word, insert a bubble, or hold.
// Load and bubble are never asserted together by the fetch FSM.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter word_t BUBBLE_INSTR = fetch_stage_pkg::NOP_INSTR
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  bubble,
  input  word_t instr_in,
  input  word_t pc_plus2_in,
  output word_t instr,
  output word_t pc_plus2,
  output logic  valid
);

  always_ff @(posedge clk) begin
    if (rst) begin
      instr    <= BUBBLE_INSTR;
      pc_plus2 <= '0;
      valid    <= 1'b0;
    end else if (load) begin
      instr    <= instr_in;
      pc_plus2 <= pc_plus2_in;
      valid    <= 1'b1;
    end else if (bubble) begin
      // pc_plus2 is left as-is; decode ignores it when valid is low
      instr    <= BUBBLE_INSTR;
      valid    <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, cache request, miss/stall/flush/HLT handling, IF/ID register.
// Hit lands in IF/ID one cycle after the address is presented; misses/flushes insert bubbles.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter word_t RESET_PC  = 16'h0000,
  parameter word_t NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master imem,
  input  logic          stall,
  input  logic          flush,
  input  word_t         branch_target,
  output word_t         pc,
  output word_t         if_id_instr,
  output word_t         if_id_pc_plus2,
  output logic          if_id_valid,
  output logic          halted,
  output word_t         miss_cycles
);

  fetch_state_e state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        pc_plus2;
  logic         ld_ifid, bub_ifid;
  logic         halted_q;
  word_t        miss_q;

  assign pc_plus2       = pc_q + 16'd2;
  assign imem.imem_addr = pc_q;
  assign imem.imem_req  = (state_q != ST_HALT);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ld_ifid  = 1'b0;
    bub_ifid = 1'b0;
    case (state_q)
      ST_FETCH, ST_MISS: begin
        if (flush) begin
          pc_d     = branch_target & 16'hFFFE;
          bub_ifid = 1'b1;
          state_d  = ST_FETCH;
        end else if (!stall) begin
          if (imem.imem_valid) begin
            ld_ifid = 1'b1;
            // HLT freezes the PC at its own address
            if (is_hlt(imem.imem_instr)) begin
              state_d = ST_HALT;
            end else begin
              pc_d    = pc_plus2;
              state_d = ST_FETCH;
            end
          end else begin
            bub_ifid = 1'b1;
            state_d  = ST_MISS;
          end
        end
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
      miss_q   <= '0;
    end else begin
      pc_q     <= pc_d;
      halted_q <= (state_d == ST_HALT);
      if (state_q == ST_MISS && miss_q != 16'hFFFF) miss_q <= miss_q + 16'd1;
    end
  end

  if_id_reg #(
    .BUBBLE_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk         (clk),
    .rst         (rst),
    .load        (ld_ifid),
    .bubble      (bub_ifid),
    .instr_in    (imem.imem_instr),
    .pc_plus2_in (pc_plus2),
    .instr       (if_id_instr),
    .pc_plus2    (if_id_pc_plus2),
    .valid       (if_id_valid)
  );

  assign pc          = pc_q;
  assign halted      = halted_q;
  assign miss_cycles = miss_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed and randomized checks of fetch_stage against a rule-level reference model.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic  clk = 1'b0;
  logic  rst;
  logic  stall, flush;
  word_t branch_target;
  word_t pc, if_id_instr, if_id_pc_plus2, miss_cycles;
  logic  if_id_valid, halted;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  fetch_stage_if imem_bus();

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .imem           (imem_bus.master),
    .stall          (stall),
    .flush          (flush),
    .branch_target  (branch_target),
    .pc             (pc),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus2 (if_id_pc_plus2),
    .if_id_valid    (if_id_valid),
    .halted         (halted),
    .miss_cycles    (miss_cycles)
  );

  always #5 clk = ~clk;

  // Reference model: architectural view of the fetch stage
  word_t m_pc, m_instr, m_pp2, m_miss;
  logic  m_valid, m_halted, m_in_miss;
  logic  m_known = 1'b0;

  task automatic check(input string tag, input word_t obs, input word_t exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic v, input word_t ins,
                            input logic st, input logic fl, input word_t tgt);
    word_t op;
    op = ins >> 12;
    if (r) begin
      m_pc = 16'h0000; m_instr = 16'h0000; m_pp2 = 16'h0000;
      m_valid = 1'b0; m_halted = 1'b0; m_in_miss = 1'b0; m_miss = 16'h0000;
      m_known = 1'b1;
    end else if (!m_halted) begin
      if (m_in_miss && m_miss != 16'hFFFF) m_miss = m_miss + 16'd1;
      if (fl) begin
        m_pc = {tgt[15:1], 1'b0};
        m_instr = 16'h0000; m_valid = 1'b0; m_in_miss = 1'b0;
      end else if (!st) begin
        if (v) begin
          m_instr = ins; m_pp2 = m_pc + 16'd2; m_valid = 1'b1; m_in_miss = 1'b0;
          if (op == 16'h000F) m_halted = 1'b1;
          else m_pc = m_pc + 16'd2;
        end else begin
          m_instr = 16'h0000; m_valid = 1'b0; m_in_miss = 1'b1;
        end
      end
    end
  endtask

  task automatic cyc(input logic r, input logic v, input word_t ins,
                     input logic st, input logic fl, input word_t tgt);
    rst = r; imem_bus.imem_valid = v; imem_bus.imem_instr = ins;
    stall = st; flush = fl; branch_target = tgt;
    if (m_known) begin
      check("imem_addr", imem_bus.imem_addr, m_pc);
      check("imem_req", {15'd0, imem_bus.imem_req}, {15'd0, !m_halted});
    end
    @(posedge clk);
    model_step(r, v, ins, st, fl, tgt);
    #1;
    check("pc", pc, m_pc);
    check("if_id_instr", if_id_instr, m_instr);
    check("if_id_valid", {15'd0, if_id_valid}, {15'd0, m_valid});
    if (m_valid) check("if_id_pc_plus2", if_id_pc_plus2, m_pp2);
    check("halted", {15'd0, halted}, {15'd0, m_halted});
    check("miss_cycles", miss_cycles, m_miss);
  endtask

  initial begin
    logic  r, v, st, fl;
    word_t ins, tgt;

    // Reset
    cyc(1, 0, 16'h0000, 0, 0, 16'h0000);
    cyc(1, 0, 16'h0000, 0, 0, 16'h0000);
    check("rst_pp2", if_id_pc_plus2, 16'h0000);

    // Three consecutive hits
    cyc(0, 1, 16'h1123, 0, 0, 16'h0000);
    check("hit0_pp2", if_id_pc_plus2, 16'h0002);
    cyc(0, 1, 16'h2456, 0, 0, 16'h0000);
    check("hit1_pp2", if_id_pc_plus2, 16'h0004);
    cyc(0, 1, 16'h0789, 0, 0, 16'h0000);
    check("hit2_instr", if_id_instr, 16'h0789);
    check("hit2_pp2", if_id_pc_plus2, 16'h0006);

    // Four-cycle miss at 0x0010
    cyc(0, 0, 16'h0000, 0, 1, 16'h0010);
    for (int i = 0; i < 4; i++) cyc(0, 0, 16'hAAAA, 0, 0, 16'h0000);
    check("miss_pc", pc, 16'h0010);
    cyc(0, 1, 16'h3A5A, 0, 0, 16'h0000);
    check("miss_cnt", miss_cycles, 16'd4);
    check("miss_deliver", if_id_instr, 16'h3A5A);

    // Two-cycle stall after a hit at 0x0020
    cyc(0, 0, 16'h0000, 0, 1, 16'h0020);
    cyc(0, 1, 16'h3333, 0, 0, 16'h0000);
    cyc(0, 1, 16'h4444, 1, 0, 16'h0000);
    cyc(0, 1, 16'h4444, 1, 0, 16'h0000);
    check("stall_pc", pc, 16'h0022);
    check("stall_instr", if_id_instr, 16'h3333);
    cyc(0, 1, 16'h5555, 0, 0, 16'h0000);
    check("after_stall_pp2", if_id_pc_plus2, 16'h0024);

    // Flush beats stall and a fetched HLT
    cyc(0, 1, 16'hF000, 1, 1, 16'h0101);
    check("flush_pc", pc, 16'h0100);
    check("flush_nohalt", {15'd0, halted}, 16'h0000);

    // PC wrap
    cyc(0, 0, 16'h0000, 0, 1, 16'hFFFE);
    cyc(0, 1, 16'h1234, 0, 0, 16'h0000);
    check("wrap_pc", pc, 16'h0000);
    check("wrap_pp2", if_id_pc_plus2, 16'h0000);

    // HLT at 0x0040, flush ignored, reset clears
    cyc(0, 0, 16'h0000, 0, 1, 16'h0040);
    cyc(0, 1, 16'hF000, 0, 0, 16'h0000);
    check("hlt_halted", {15'd0, halted}, 16'h0001);
    check("hlt_pc", pc, 16'h0040);
    cyc(0, 1, 16'h1111, 0, 1, 16'h0200);
    check("hlt_flush_pc", pc, 16'h0040);
    check("hlt_req", {15'd0, imem_bus.imem_req}, 16'h0000);
    cyc(1, 0, 16'h0000, 0, 0, 16'h0000);
    check("hlt_rst_halted", {15'd0, halted}, 16'h0000);

    // Randomized traffic including mid-miss and mid-halt resets
    for (int i = 0; i < 600; i++) begin
      r   = ($urandom_range(0, 59) == 0);
      v   = ($urandom_range(0, 3) != 0);
      st  = ($urandom_range(0, 4) == 0);
      fl  = ($urandom_range(0, 14) == 0);
      tgt = word_t'($urandom);
      ins = word_t'($urandom);
      if (ins[15:12] == 4'hF && $urandom_range(0, 7) != 0) ins[15:12] = 4'h2;
      cyc(r, v, ins, st, fl, tgt);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined 16-bit core. Holds the PC, requests instructions from the instruction cache, and owns the IF/ID pipeline register whose `instr[15:12]` drives the opcode decoder. Handles cache-miss waits, hazard stalls, branch redirects and HLT detection, so decode always sees either a valid instruction or an explicit bubble.

## Interface
Parameters:
- `RESET_PC`, 16'h0000, PC value loaded on reset
- `NOP_INSTR`, 16'h0000, encoding placed in IF/ID for a bubble

Ports:
- `clk`  in  1  core clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `imem_addr`  out  16  fetch address, always equals `pc`
- `imem_req`  out  1  fetch request; high in FETCH and MISS states
- `imem_instr`  in  16  instruction word, meaningful only when `imem_valid`
- `imem_valid`  in  1  cache hit / fill complete for current `imem_addr`
- `stall`  in  1  hazard unit: hold PC and IF/ID
- `flush`  in  1  taken branch resolved in decode: redirect and squash
- `branch_target`  in  16  redirect PC, sampled when `flush`
- `pc`  out  16  current fetch PC
- `if_id_instr`  out  16  instruction to decode
- `if_id_pc_plus2`  out  16  PC+2 of that instruction (PCS / branch base)
- `if_id_valid`  out  1  IF/ID holds a real instruction
- `halted`  out  1  HLT has reached IF/ID; fetch frozen
- `miss_cycles`  out  16  count of cycles spent in MISS, saturating

## Operation
- States: FETCH, MISS, HALT. Reset: state FETCH, `pc`=RESET_PC, `if_id_instr`=NOP_INSTR, `if_id_pc_plus2`=0, `if_id_valid`=0, `halted`=0, `miss_cycles`=0.
- Priority per cycle: `rst` > `flush` > `stall` > memory.
- FETCH, `imem_valid`=1, no stall/flush: IF/ID <= {imem_instr, pc+2, valid=1}; `pc` <= pc+2. If `imem_instr[15:12]`==4'b1111 (HLT): `pc` unchanged, next state HALT.
- FETCH, `imem_valid`=0: IF/ID <= bubble (NOP_INSTR, valid 0), `pc` held, next MISS.
- MISS: `miss_cycles` += 1 each cycle (saturates at 16'hFFFF); bubble into IF/ID unless stalled; on `imem_valid`=1 behave as FETCH hit and return to FETCH (or HALT).
- `stall` (no flush): PC, IF/ID, state frozen; memory response discarded and re-requested next cycle.
- `flush`: `pc` <= branch_target, IF/ID <= bubble, next FETCH, from FETCH or MISS; any fetched word (including HLT) discarded that cycle.
- HALT: `imem_req`=0, `pc` frozen at HLT address, IF/ID holds HLT with valid 1, `halted`=1. `flush` and `stall` ignored. Only `rst` exits.
- PC arithmetic modulo 2^16: 16'hFFFE+2 = 16'h0000. `branch_target[0]` forced to 0.

## Timing
- Hit latency: instruction presented at `imem_addr` in cycle N appears on `if_id_instr` in cycle N+1.
- Miss of k cycles (`imem_valid` low k cycles): k bubbles into IF/ID, `miss_cycles` += k.
- Flush: target fetched cycle after `flush`; exactly one bubble seen by decode.
- `halted` rises the cycle after HLT is accepted; stays high until `rst`.
- Reset mid-miss or mid-halt: all outputs return to reset values next edge.
- All outputs registered except `imem_addr`/`imem_req` (decoded from `pc`/state).

## Structure
- Shared package: opcode constants (OP_HLT=4'b1111, OP_B, OP_BR, OP_PCS), NOP_INSTR, fetch state enum.
- One sub-module: `if_id_reg` (IF/ID pipeline register with load/hold/bubble control); FSM, PC and counter stay in `fetch_stage`.

## Test plan
- Reset, then three hits at 0,2,4 returning 16'h1123,16'h2456,16'h0789 -> IF/ID shows each next cycle with pc_plus2 2,4,6, valid 1.
- `imem_valid` low 4 cycles at pc=16'h0010 -> 4 bubbles (valid 0), pc held 16'h0010, `miss_cycles`=4, then instruction delivered.
- `stall` 2 cycles after a hit at 16'h0020 -> pc and IF/ID unchanged both cycles, no double fetch.
- `flush` with `branch_target`=16'h0100 while `stall` high and HLT word on `imem_instr` -> pc=16'h0100, bubble, no halt.
- HLT (16'hF000) fetched at 16'h0040 -> `halted`=1 next cycle, pc stays 16'h0040, `imem_req`=0, later `flush` ignored; `rst` clears all.
- PC at 16'hFFFE hit -> pc wraps to 16'h0000, pc_plus2 16'h0000.
